// File: rtl/mtr_pwm_if.sv
// Speed-command and H-bridge leg bundle between the SegwayMath producer and mtr_pwm_drv.
// master drives commands/enable/fault and observes the legs; slave is the PWM driver.
interface mtr_pwm_if;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        en;
  logic        fault;
  logic        lft_fwd;
  logic        lft_rev;
  logic        rght_fwd;
  logic        rght_rev;
  logic        PWM_synch;
  logic        flt_latched;

  modport master (
    output lft_spd, rght_spd, en, fault,
    input  lft_fwd, lft_rev, rght_fwd, rght_rev, PWM_synch, flt_latched
  );

  modport slave (
    input  lft_spd, rght_spd, en, fault,
    output lft_fwd, lft_rev, rght_fwd, rght_rev, PWM_synch, flt_latched
  );
endinterface

// File: rtl/mtr_pwm_drv.sv
// Two-channel H-bridge PWM driver: period-buffered duty, dead periods on reversal, sticky fault.
// Legs lag the counter by one clock; fault blanks the legs from the clock after it is seen.
module mtr_pwm_drv #(
  parameter int CNT_W    = 11,
  parameter int DEAD_PER = 2
) (
  input  logic     clk,
  input  logic     rst,
  mtr_pwm_if.slave bus
);
  typedef enum logic [1:0] {
    ST_FWD  = 2'd0,
    ST_REV  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  localparam logic [3:0]       DEAD_LD = 4'(DEAD_PER);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_synch;
  logic             r_flt;
  state_t           r_state [2];
  state_t           r_tgt   [2];
  logic [3:0]       r_dead  [2];
  logic [CNT_W-1:0] r_mag   [2];
  logic             r_fwd   [2];
  logic             r_rev   [2];

  state_t           w_state_nxt [2];
  state_t           w_tgt_nxt   [2];
  logic [3:0]       w_dead_nxt  [2];
  logic [CNT_W-1:0] w_mag_nxt   [2];
  logic             w_fwd_nxt   [2];
  logic             w_rev_nxt   [2];
  logic [11:0]      w_spd       [2];
  logic [10:0]      w_abs       [2];
  logic [CNT_W-1:0] w_mag_smp   [2];
  logic             w_req       [2];
  logic             w_sample;
  logic             w_kill;
  logic             w_blank_smp;

  assign w_sample    = (r_cnt == {CNT_W{1'b1}});
  // A fault arriving on the sample edge already zeroes the latched duty.
  assign w_kill      = r_flt | bus.fault;
  assign w_blank_smp = ~bus.en | w_kill;
  assign w_spd[0]    = bus.lft_spd;
  assign w_spd[1]    = bus.rght_spd;

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      w_req[ch] = w_spd[ch][11];
      if (w_spd[ch] == 12'h800) begin
        w_abs[ch] = 11'h7FF;
      end else if (w_spd[ch][11]) begin
        w_abs[ch] = 11'((~w_spd[ch]) + 12'd1);
      end else begin
        w_abs[ch] = w_spd[ch][10:0];
      end
      w_mag_smp[ch] = w_blank_smp ? '0 : CNT_W'(w_abs[ch]);
    end
  end

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      w_state_nxt[ch] = r_state[ch];
      w_tgt_nxt[ch]   = r_tgt[ch];
      w_dead_nxt[ch]  = r_dead[ch];
      w_mag_nxt[ch]   = r_mag[ch];
      if (w_sample) begin
        w_mag_nxt[ch] = w_mag_smp[ch];
        case (r_state[ch])
          ST_FWD: begin
            if (w_req[ch] && (w_mag_smp[ch] != '0)) begin
              w_state_nxt[ch] = ST_DEAD;
              w_tgt_nxt[ch]   = ST_REV;
              w_dead_nxt[ch]  = DEAD_LD;
            end
          end
          ST_REV: begin
            if (!w_req[ch] && (w_mag_smp[ch] != '0)) begin
              w_state_nxt[ch] = ST_DEAD;
              w_tgt_nxt[ch]   = ST_FWD;
              w_dead_nxt[ch]  = DEAD_LD;
            end
          end
          ST_DEAD: begin
            if ((w_mag_smp[ch] != '0) &&
                (w_req[ch] ? (r_tgt[ch] == ST_FWD) : (r_tgt[ch] == ST_REV))) begin
              w_tgt_nxt[ch]  = w_req[ch] ? ST_REV : ST_FWD;
              w_dead_nxt[ch] = DEAD_LD;
            end else if (r_dead[ch] <= 4'd1) begin
              w_state_nxt[ch] = r_tgt[ch];
              w_dead_nxt[ch]  = 4'd0;
            end else begin
              w_dead_nxt[ch] = r_dead[ch] - 4'd1;
            end
          end
          default: w_state_nxt[ch] = ST_FWD;
        endcase
      end
    end
  end

  // Leg compare uses the pre-edge state and duty, so a state change lines up with cnt==0.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      w_fwd_nxt[ch] = ~w_kill & (r_state[ch] == ST_FWD) & (r_cnt < r_mag[ch]);
      w_rev_nxt[ch] = ~w_kill & (r_state[ch] == ST_REV) & (r_cnt < r_mag[ch]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_synch <= 1'b0;
      r_flt   <= 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        r_state[ch] <= ST_FWD;
        r_tgt[ch]   <= ST_FWD;
        r_dead[ch]  <= 4'd0;
        r_mag[ch]   <= '0;
        r_fwd[ch]   <= 1'b0;
        r_rev[ch]   <= 1'b0;
      end
    end else begin
      r_cnt   <= r_cnt + CNT_ONE;
      r_synch <= (r_cnt == '0);
      if (bus.fault) begin
        r_flt <= 1'b1;
      end
      for (int ch = 0; ch < 2; ch++) begin
        r_state[ch] <= w_state_nxt[ch];
        r_tgt[ch]   <= w_tgt_nxt[ch];
        r_dead[ch]  <= w_dead_nxt[ch];
        r_mag[ch]   <= w_mag_nxt[ch];
        r_fwd[ch]   <= w_fwd_nxt[ch];
        r_rev[ch]   <= w_rev_nxt[ch];
      end
    end
  end

  assign bus.lft_fwd     = r_fwd[0];
  assign bus.lft_rev     = r_rev[0];
  assign bus.rght_fwd    = r_fwd[1];
  assign bus.rght_rev    = r_rev[1];
  assign bus.PWM_synch   = r_synch;
  assign bus.flt_latched = r_flt;
endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Directed bench for mtr_pwm_drv: per-period high-clock counts per leg, synch pulse count,
// leg overlap, dead periods, enable gating, fault latch and reset recovery.
module tb_mtr_pwm_drv;
  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  mtr_pwm_if bus();

  mtr_pwm_drv #(.CNT_W(11), .DEAD_PER(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Window starts on the PWM_synch cycle and spans 2048 clocks: exactly one period of leg output.
  task automatic period_chk(input string tag,
                            input int elf, input int elr, input int erf, input int err,
                            input int mid_idx = -1, input logic [11:0] mid_val = 12'h000);
    int n   = 0;
    int lf  = 0;
    int lr  = 0;
    int rf  = 0;
    int rr  = 0;
    int sy  = 0;
    int ovl = 0;
    while (bus.PWM_synch !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".synch_seen"}, int'(bus.PWM_synch === 1'b1), 1);
    for (int i = 0; i < 2048; i++) begin
      if (i > 0) @(negedge clk);
      if (i == mid_idx) bus.rght_spd = mid_val;
      lf  += int'(bus.lft_fwd === 1'b1);
      lr  += int'(bus.lft_rev === 1'b1);
      rf  += int'(bus.rght_fwd === 1'b1);
      rr  += int'(bus.rght_rev === 1'b1);
      sy  += int'(bus.PWM_synch === 1'b1);
      ovl += int'(((bus.lft_fwd & bus.lft_rev) | (bus.rght_fwd & bus.rght_rev)) !== 1'b0);
    end
    check({tag, ".lft_fwd_hi"},  lf,  elf);
    check({tag, ".lft_rev_hi"},  lr,  elr);
    check({tag, ".rght_fwd_hi"}, rf,  erf);
    check({tag, ".rght_rev_hi"}, rr,  err);
    check({tag, ".synch_pulses"}, sy, 1);
    check({tag, ".leg_overlap"}, ovl, 0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.lft_spd  = 12'h400;
    bus.rght_spd = 12'h100;
    bus.en       = 1'b1;
    bus.fault    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.lft_fwd",   int'(bus.lft_fwd),     0);
    check("rst.lft_rev",   int'(bus.lft_rev),     0);
    check("rst.rght_fwd",  int'(bus.rght_fwd),    0);
    check("rst.rght_rev",  int'(bus.rght_rev),    0);
    check("rst.synch",     int'(bus.PWM_synch),   0);
    check("rst.flt",       int'(bus.flt_latched), 0);
    rst = 1'b0;

    period_chk("p0_idle",    0,    0, 0,   0);
    period_chk("p1_half",    1024, 0, 256, 0);
    period_chk("p2_midchg",  1024, 0, 256, 0, 1000, 12'h300);
    period_chk("p3_newduty", 1024, 0, 768, 0);

    bus.lft_spd = 12'h800;
    period_chk("p4_oldfwd",  1024, 0,    768, 0);
    period_chk("p5_dead1",   0,    0,    768, 0);
    period_chk("p6_dead2",   0,    0,    768, 0);
    period_chk("p7_revsat",  0,    2047, 768, 0);

    bus.lft_spd = 12'h000;
    period_chk("p8_rev",     0, 2047, 768, 0);
    period_chk("p9_zero",    0, 0,    768, 0);
    bus.lft_spd = 12'hF00;
    period_chk("p10_zero",   0, 0,    768, 0);
    period_chk("p11_nodead", 0, 256,  768, 0);

    bus.en = 1'b0;
    period_chk("p12_en_late", 0, 256, 768, 0);
    bus.en = 1'b1;
    period_chk("p13_disabled", 0, 0,   0,   0);
    period_chk("p14_resume",   0, 256, 768, 0);

    repeat (100) @(negedge clk);
    check("pre_fault.lft_rev",  int'(bus.lft_rev),  1);
    check("pre_fault.rght_fwd", int'(bus.rght_fwd), 1);
    bus.fault = 1'b1;
    @(negedge clk);
    bus.fault = 1'b0;
    check("fault.lft_rev",  int'(bus.lft_rev),     0);
    check("fault.rght_fwd", int'(bus.rght_fwd),    0);
    check("fault.flt",      int'(bus.flt_latched), 1);

    bus.lft_spd  = 12'h400;
    bus.rght_spd = 12'hC00;
    period_chk("f1_blank", 0, 0, 0, 0);
    period_chk("f2_blank", 0, 0, 0, 0);
    check("fault.sticky", int'(bus.flt_latched), 1);

    rst = 1'b1;
    @(negedge clk);
    check("rst2.flt",     int'(bus.flt_latched), 0);
    check("rst2.lft_fwd", int'(bus.lft_fwd),     0);
    @(negedge clk);
    rst = 1'b0;

    period_chk("r0_idle",  0,    0, 0, 0);
    period_chk("r1_fwd",   1024, 0, 0, 0);
    period_chk("r2_fwd",   1024, 0, 0, 0);
    period_chk("r3_rrev",  1024, 0, 0, 1024);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mtr_pwm_drv.md
Name: mtr_pwm_drv

Overview:
- Consumer end of the SegwayMath speed interface.
- Takes the signed 12-bit lft_spd/rght_spd commands and drives two H-bridge channels (fwd/rev legs each) with 11-bit PWM.
- Duty is double-buffered at period boundaries, a dead period is inserted on direction reversal, and there is a sticky fault shutdown.
- Sits between SegwayMath and the motor driver pads; provides PWM_synch for downstream A2D/sampling alignment.

Parameters:
- CNT_W, 11, PWM counter width; period = 2^CNT_W clocks.
- DEAD_PER, 2, full PWM periods both legs held low on direction change (1..15).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- lft_spd  input  12  signed left speed command (two's complement)
- rght_spd  input  12  signed right speed command
- en  input  1  drive enable; sampled at the period boundary
- fault  input  1  over-current/too_fast fault request, synchronous
- lft_fwd  output  1  left forward-leg PWM
- lft_rev  output  1  left reverse-leg PWM
- rght_fwd  output  1  right forward-leg PWM
- rght_rev  output  1  right reverse-leg PWM
- PWM_synch  output  1  one-clock pulse at period start
- flt_latched  output  1  sticky fault indicator

Behaviour:
- Reset (rst=1 at a clk edge): cnt=0, shadow magnitudes=0, dir=FWD, both channel FSMs=FWD, dead counters=0, flt_latched=0, all four PWM outputs=0, PWM_synch=0. Reset mid-period takes effect at that edge; no output glitch beyond one clock.
- Counter: cnt[CNT_W-1:0] is free-running, +1 per clk, wraps 2047->0.
- PWM_synch: registered; high for the one cycle following cnt==0, so exactly once per 2048 clocks.
- Sampling: on the clock where cnt==2047, each channel latches:
  - mag = |spd|, saturating -2048 -> 2047;
  - req_dir = spd[11];
  - mag forced to 0 if en=0 or flt_latched=1.
- Inputs are ignored at all other cycles; the new duty applies from the next period.
- PWM compare: raw = (cnt < mag), registered.
  - The output lags cnt by one clock.
  - High for exactly mag clocks per period.
  - mag=0 gives a constant 0; mag=2047 gives 2047/2048 high.
- Per-channel FSM, states FWD, REV, DEAD, evaluated only at the sample point:
  - FWD: req_dir=1 and mag!=0 -> DEAD, target=REV, dead_cnt=DEAD_PER. Otherwise stay.
  - REV: req_dir=0 and mag!=0 -> DEAD, target=FWD. A 0 command never causes a reversal, so direction is held.
  - DEAD: dead_cnt decrements each sample point; at 1 -> target state. A new opposite request during DEAD retargets and reloads dead_cnt.
- Leg drive:
  - FWD: fwd=raw, rev=0.
  - REV: rev=raw, fwd=0.
  - DEAD: both 0.
  - fwd&rev is never 1 in the same cycle, in any state.
- Fault: fault=1 at any edge sets flt_latched. From the next clock, all four legs are forced to 0 immediately (not at the period boundary). Cleared only by rst.
- Channels are fully independent; left and right share cnt and PWM_synch.
- Simultaneous fault and sample point: fault wins, and the sampled mag is forced to 0.

Test Plan:
- rst for 2 clks, lft_spd=12'h400, en=1 -> after the first cnt==2047 sample, lft_fwd is high for 1024 consecutive clocks per 2048-clock period, lft_rev=0; PWM_synch is a single pulse every 2048 clocks.
- lft_spd=12'h800 (-2048) from FWD -> DEAD: both legs 0 for 2 full periods; then lft_rev high 2047 clocks/period (saturation), lft_fwd=0.
- rght_spd switches 12'h100 -> 12'h300 mid-period -> the current period keeps 256 high clocks; the next period has 768.
- lft_spd=0 while in REV -> lft_rev=0 all period, FSM stays REV, and no dead period appears on a subsequent negative command.
- en=0 at sample -> all legs 0 next period; en=1 again -> duty resumes the following period with no dead time.
- fault pulse of 1 clock mid-high-phase -> legs 0 from the next clk and flt_latched=1; both persist through further speed changes until rst, after which the FSM is FWD with mag=0.
- Assertion throughout: never (lft_fwd&lft_rev) or (rght_fwd&rght_rev).
